fp_round_pipe: RTL
==================

# fp_round_pipe

Parametrised two-stage FPU rounding/packing pipeline. It succeeds the single-stage float32 post-processor and supports any IEEE-754 binary format via `EXP_W`/`MAN_W`. It registers every output, supports full-throughput backpressure across both stages, and adds RMM rounding. It sits at the tail of every FPU datapath (add, mul, div, sqrt, convert) and produces the packed result plus the `fflags` bits.

## Interface
- `EXP_W`, 8: exponent field width (11 for binary64, 5 for binary16).
- `MAN_W`, 23: stored mantissa width, without the hidden bit.
- Derived, not overridable: `BIAS = 2^(EXP_W-1)-1`, `FW = 1+EXP_W+MAN_W`.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous kill of all in-flight results.
- `valid_in` in 1, `ready_out` out 1: upstream handshake.
- `valid_out` out 1, `ready_in` in 1: downstream handshake.
- `rm` in 3: rounding mode. RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100. Codes 101–111 are treated as RNE.
- `man_in` in MAN_W+1: normalised mantissa, hidden bit at MSB.
- `exp_in` in EXP_W+2: signed unbiased exponent.
- `sgn_in` in 1: sign.
- `round_bit`, `sticky_bit` in 1 each: guard bits below the `man_in` LSB.
- `skip_round` in 1: input is already a special/packed value.
- `IV_in`, `DZ_in` in 1 each: flags passed through on the skip path.
- `float_out` out FW: packed result, registered.
- `IV`, `DZ`, `OF`, `UF`, `IE` out 1 each: exception flags, registered, aligned with `float_out`.

## Operation
- **Stage 1 (denormalise):**
  - `eb = exp_in + BIAS`, computed in EXP_W+2 bits.
  - `tiny_eq = (eb == 0)`; `tiny_lt = eb[MSB]`.
  - If `tiny_eq` or `tiny_lt`: `off = 1 - eb` and `eb` is forced to 0. Otherwise `off = 0`.
  - `{man_in, round_bit}` is right-shifted by `off`, saturated at MAN_W+2. All bits shifted out OR into sticky, together with `sticky_bit`.
  - Registers `man[MAN_W-1:0]`, round, sticky, `eb`, sgn, rm, `tiny_eq`, `tiny_lt`, `skip`, `IV_in`, `DZ_in`.
- **Stage 1 skip path:** when `skip_round=1`, it registers `{sgn_in, exp_in[EXP_W-1:0], man_in[MAN_W-1:0]}` unchanged, with round=sticky=0.
- **Stage 2 (round/pack):**
  - Increment decision:
    - RNE: `r & (s | lsb)`.
    - RTZ: 0.
    - RDN: `(r|s) & sgn`.
    - RUP: `(r|s) & !sgn`.
    - RMM: `r`.
  - `inexact = r | s`.
  - The mantissa carry-out increments `eb`. This includes a denormal rounding to the minimum normal.
- **Overflow:** if the rounded exponent ≥ `2^EXP_W - 1` (including carry bits), then OF=IE=1 and UF=0.
  - RTZ, RDN with sgn=0, or RUP with sgn=1: result is max finite `{sgn, 1..10, 1..1}`.
  - All other cases: result is `{sgn, all-ones, 0}` (Inf).
- **Underflow:** UF=IE=1 when `inexact & (tiny_lt | (tiny_eq & !carry))`. Otherwise IE=`inexact`, UF=0.
- **Skip path in stage 2:** value passes through, `IV`/`DZ` come from the inputs, and OF=UF=IE=0. In the non-skip path, IV=DZ=0.

## Timing
- Latency is 2 cycles from input acceptance to `valid_out`. Throughput is 1 result per cycle.
- Per-stage valid bits `v1`, `v2`:
  - `adv2 = !v2 | ready_in`
  - `adv1 = !v1 | adv2`
  - `ready_out = adv1`, a combinational path from `ready_in` (permitted).
- Stage 2 loads from stage 1 when `v1 & adv2`. Stage 1 loads when `valid_in & ready_out`.
- A stage that is emptied and refilled in the same cycle keeps its valid bit at 1, with no bubble.
- `valid_out = v2 & !flush`.
- `float_out` and the flags hold stable while `valid_out & !ready_in`. They are don't-care when `valid_out=0`.
- `flush` clears `v1` and `v2` at the next edge. An input presented in the same cycle as `flush` is dropped.
- Reset values: all pipeline registers 0, so `valid_out=0`, `float_out=0`, all flags 0. `ready_out` reads 1 while in reset.
- Reset asserted mid-operation discards both stages immediately (asynchronous).

## Test plan
- **Exact normal, float32, RNE:** `exp_in=0`, `man_in=0x800000`, r=s=0 → 2 cycles later `float_out=0x3F800000`, no flags. Same stimulus with `EXP_W=11`, `MAN_W=52` → `0x3FF0000000000000`.
- **Ties:** `man_in=0x800001`, r=1, s=0.
  - RNE → `0x3F800002`, IE=1.
  - RTZ → `0x3F800001`, IE=1.
  - RMM with `man_in=0x800000`, r=1 → `0x3F800001`.
- **Overflow:** `exp_in=128`, `man_in=0x800000`.
  - RNE → `0x7F800000`, OF=IE=1.
  - RTZ → `0x7F7FFFFF`.
  - RUP with sgn=1 → `0xFF7FFFFF`.
- **Denormals:**
  - `exp_in=-127`, `man_in=0x800000` → `0x00400000`, no flags.
  - `exp_in=-149`, `man_in=0xC00000`, RNE → `0x00000002`, UF=IE=1.
  - `exp_in=-127`, `man_in=0xFFFFFF`, r=1, RNE → `0x00800000`, UF=0, IE=1.
- **Backpressure:** 4 back-to-back inputs with `ready_in=0` for 3 cycles.
  - `ready_out` drops after 2 inputs are held.
  - No loss or duplication; results appear in order.
  - After `ready_in=1`, results flow 1 per cycle.
- **Skip and flush:**
  - `skip_round=1`, `IV_in=1`, packed `0x7FC00000` → output unchanged, IV=1, other flags 0.
  - `flush` asserted with both stages full → `valid_out=0` that cycle and the next.
  - Asynchronous `reset` pulse mid-stream → all outputs 0.

Source files
------------

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 rounding/packing pipeline for any binary
// format selected by EXP_W/MAN_W. Stage 1 denormalises tiny results. Stage 2
// rounds the value, packs it and registers it together with the exception
// flags.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   flush                synchronous kill of both pipeline stages
//   valid_in/ready_out   upstream handshake (ready_out is combinational)
//   valid_out/ready_in   downstream handshake
//   rm                   rounding mode (RNE/RTZ/RDN/RUP/RMM, unused codes = RNE)
//   man_in, exp_in       normalised mantissa (hidden bit at MSB), signed unbiased exponent
//   sgn_in               sign
//   round_bit/sticky_bit guard bits below the man_in LSB
//   skip_round           input is already packed {sgn, exp, man}
//   IV_in, DZ_in         flags forwarded on the skip path
//   float_out            packed result
//   IV, DZ, OF, UF, IE   exception flags aligned with float_out
module fp_round_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   valid_in,
   output logic                   ready_out,
   output logic                   valid_out,
   input  logic                   ready_in,
   input  logic [2:0]             rm,
   input  logic [MAN_W:0]         man_in,
   input  logic [EXP_W+1:0]       exp_in,
   input  logic                   sgn_in,
   input  logic                   round_bit,
   input  logic                   sticky_bit,
   input  logic                   skip_round,
   input  logic                   IV_in,
   input  logic                   DZ_in,
   output logic [EXP_W+MAN_W:0]   float_out,
   output logic                   IV,
   output logic                   DZ,
   output logic                   OF,
   output logic                   UF,
   output logic                   IE
);

   localparam int unsigned EW2 = EXP_W + 2;
   localparam int unsigned NW  = MAN_W + 2;
   localparam int unsigned SW  = $clog2(NW + 1);
   localparam int unsigned FW  = 1 + EXP_W + MAN_W;

   localparam logic [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW2:0]   EMAX = (EW2 + 1)'((1 << EXP_W) - 1);

   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // Valid bits and handshake
   logic v1_q, v1_d, v2_q, v2_d;
   logic adv1_c, adv2_c;

   // Stage-1 registers
   logic [MAN_W-1:0] man1_q, man1_d;
   logic             rnd1_q, rnd1_d, stk1_d, stk1_q;
   logic [EW2-1:0]   eb1_q, eb1_d;
   logic             sgn1_q, sgn1_d;
   logic [2:0]       rm1_q, rm1_d;
   logic             teq1_q, teq1_d, tlt1_q, tlt1_d;
   logic             skip1_q, skip1_d, iv1_q, iv1_d, dz1_q, dz1_d;

   // Stage-2 (output) registers
   logic [FW-1:0]    float_q, float_d;
   logic             iv_q, iv_d, dz_q, dz_d, of_q, of_d, uf_q, uf_d, ie_q, ie_d;

   // Stage-1 combinational datapath
   logic [EW2-1:0]   eb_raw_c, off_c;
   logic             tiny_eq_c, tiny_lt_c;
   logic [SW-1:0]    off_sat_c;
   logic [2*NW-2:0]  ext_c;
   logic             lost_c;

   // Stage-2 combinational datapath
   logic             inc_c, inexact_c, carry_c, ovf_c, maxfin_c;
   logic [MAN_W:0]   man_sum_c;
   logic [EW2:0]     eb_r_c;

   // Handshake: a stage may advance when it is empty or its successor advances
   always_comb begin
      adv2_c    = !v2_q || ready_in;
      adv1_c    = !v1_q || adv2_c;
      ready_out = adv1_c;
      valid_out = v2_q && !flush;
   end

   // Denormalise: shift {man_in, round_bit} right for tiny exponents
   always_comb begin
      eb_raw_c  = exp_in + BIAS;
      tiny_eq_c = (eb_raw_c == '0);
      tiny_lt_c = eb_raw_c[EW2-1];
      off_c     = (tiny_eq_c || tiny_lt_c) ? (EW2'(1) - eb_raw_c) : '0;
      off_sat_c = (32'(off_c) > 32'(NW)) ? SW'(NW) : SW'(off_c);
      // Upper half holds the shifted {man, round}; the hidden bit is dropped
      // because it only survives (as a mantissa bit) when off >= 1.
      ext_c     = (2*NW-1)'({man_in, round_bit, NW'(0)} >> off_sat_c);
      lost_c    = |ext_c[NW-1:0];
   end

   // Stage-1 next state
   always_comb begin
      v1_d    = v1_q;
      man1_d  = man1_q;
      rnd1_d  = rnd1_q;
      stk1_d  = stk1_q;
      eb1_d   = eb1_q;
      sgn1_d  = sgn1_q;
      rm1_d   = rm1_q;
      teq1_d  = teq1_q;
      tlt1_d  = tlt1_q;
      skip1_d = skip1_q;
      iv1_d   = iv1_q;
      dz1_d   = dz1_q;
      if (flush) begin
         v1_d = 1'b0;
      end else if (adv1_c) begin
         v1_d = valid_in;
      end
      if (valid_in && ready_out) begin
         sgn1_d  = sgn_in;
         rm1_d   = rm;
         skip1_d = skip_round;
         iv1_d   = IV_in;
         dz1_d   = DZ_in;
         if (skip_round) begin
            man1_d = man_in[MAN_W-1:0];
            rnd1_d = 1'b0;
            stk1_d = 1'b0;
            eb1_d  = EW2'(exp_in[EXP_W-1:0]);
            teq1_d = 1'b0;
            tlt1_d = 1'b0;
         end else begin
            man1_d = ext_c[2*NW-2:NW+1];
            rnd1_d = ext_c[NW];
            stk1_d = lost_c || sticky_bit;
            eb1_d  = (tiny_eq_c || tiny_lt_c) ? '0 : eb_raw_c;
            teq1_d = tiny_eq_c;
            tlt1_d = tiny_lt_c;
         end
      end
   end

   // Round decision, mantissa increment and exponent carry
   always_comb begin
      inexact_c = rnd1_q || stk1_q;
      case (rm1_q)
         RM_RTZ:  inc_c = 1'b0;
         RM_RDN:  inc_c = inexact_c && sgn1_q;
         RM_RUP:  inc_c = inexact_c && !sgn1_q;
         RM_RMM:  inc_c = rnd1_q;
         default: inc_c = rnd1_q && (stk1_q || man1_q[0]);
      endcase
      man_sum_c = {1'b0, man1_q} + (MAN_W+1)'(inc_c);
      carry_c   = man_sum_c[MAN_W];
      eb_r_c    = {1'b0, eb1_q} + (EW2+1)'(carry_c);
      ovf_c     = (eb_r_c >= EMAX);
      maxfin_c  = (rm1_q == RM_RTZ) || ((rm1_q == RM_RDN) && !sgn1_q) ||
                  ((rm1_q == RM_RUP) && sgn1_q);
   end

   // Stage-2 next state: pack result and flags
   always_comb begin
      v2_d    = v2_q;
      float_d = float_q;
      iv_d    = iv_q;
      dz_d    = dz_q;
      of_d    = of_q;
      uf_d    = uf_q;
      ie_d    = ie_q;
      if (flush) begin
         v2_d = 1'b0;
      end else if (adv2_c) begin
         v2_d = v1_q;
      end
      if (v1_q && adv2_c) begin
         iv_d = 1'b0;
         dz_d = 1'b0;
         of_d = 1'b0;
         uf_d = 1'b0;
         ie_d = 1'b0;
         if (skip1_q) begin
            float_d = {sgn1_q, eb1_q[EXP_W-1:0], man1_q};
            iv_d    = iv1_q;
            dz_d    = dz1_q;
         end else if (ovf_c) begin
            float_d = maxfin_c ? {sgn1_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                               : {sgn1_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of_d    = 1'b1;
            ie_d    = 1'b1;
         end else begin
            float_d = {sgn1_q, eb_r_c[EXP_W-1:0], man_sum_c[MAN_W-1:0]};
            uf_d    = inexact_c && (tlt1_q || (teq1_q && !carry_c));
            ie_d    = inexact_c;
         end
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         man1_q  <= '0;
         rnd1_q  <= 1'b0;
         stk1_q  <= 1'b0;
         eb1_q   <= '0;
         sgn1_q  <= 1'b0;
         rm1_q   <= '0;
         teq1_q  <= 1'b0;
         tlt1_q  <= 1'b0;
         skip1_q <= 1'b0;
         iv1_q   <= 1'b0;
         dz1_q   <= 1'b0;
         float_q <= '0;
         iv_q    <= 1'b0;
         dz_q    <= 1'b0;
         of_q    <= 1'b0;
         uf_q    <= 1'b0;
         ie_q    <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         man1_q  <= man1_d;
         rnd1_q  <= rnd1_d;
         stk1_q  <= stk1_d;
         eb1_q   <= eb1_d;
         sgn1_q  <= sgn1_d;
         rm1_q   <= rm1_d;
         teq1_q  <= teq1_d;
         tlt1_q  <= tlt1_d;
         skip1_q <= skip1_d;
         iv1_q   <= iv1_d;
         dz1_q   <= dz1_d;
         float_q <= float_d;
         iv_q    <= iv_d;
         dz_q    <= dz_d;
         of_q    <= of_d;
         uf_q    <= uf_d;
         ie_q    <= ie_d;
      end
   end

   assign float_out = float_q;
   assign IV        = iv_q;
   assign DZ        = dz_q;
   assign OF        = of_q;
   assign UF        = uf_q;
   assign IE        = ie_q;

endmodule
